// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID. Issues sequential fetches to a
// variable-latency instruction memory, buffers PC-tagged responses in a small
// FIFO and flushes wrong-path work on a branch redirect from ID.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [63:0] pc_out,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [31:0] Nop = 32'h0000_0013;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     resp_pc_q, resp_pc_d;
    logic [63:0]     pc_hold_q, pc_hold_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] stale_q, stale_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [63:0]     pc_mem_q    [DEPTH];

    logic [CntW:0]   credit_used;
    logic [63:0]     redir_target;
    logic            handshake;
    logic            enq;
    logic            deq;

    // Credits cover both buffered entries and in-flight requests, so every
    // accepted request is guaranteed a FIFO slot when its response returns.
    assign credit_used  = {1'b0, count_q} + {1'b0, outst_q};
    assign redir_target = redirect_pc & ~64'd3;

    assign imem_req    = rst && (state_q == StRun) && !redirect &&
                         (credit_used < {1'b0, DepthCnt});
    assign imem_addr   = fetch_pc_q;
    assign handshake   = imem_req && imem_ready;

    assign instr_valid = (count_q != '0);
    assign deq         = instr_valid && !stall;
    assign enq         = rst && (state_q == StRun) && !redirect && imem_rvalid;

    assign instr_out   = instr_valid ? instr_mem_q[head_q] : Nop;
    assign pc_out      = instr_valid ? pc_mem_q[head_q] : pc_hold_q;

    // Next-state for fetch/response PCs, credit counters, FIFO pointers and FSM.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        stale_d    = stale_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pc_hold_d  = instr_valid ? pc_mem_q[head_q] : pc_hold_q;

        if (redirect) begin
            fetch_pc_d = redir_target;
            resp_pc_d  = redir_target;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            // A response landing in the redirect cycle is dropped right here.
            stale_d    = outst_q - CntW'(imem_rvalid && (outst_q != '0));
            outst_d    = stale_d;
            state_d    = (stale_d != '0) ? StDrain : StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (handshake) begin
                        fetch_pc_d = fetch_pc_q + 64'd4;
                    end
                    if (enq) begin
                        tail_d    = tail_q + PtrW'(1);
                        resp_pc_d = resp_pc_q + 64'd4;
                    end
                    outst_d = outst_q + CntW'(handshake) - CntW'(enq);
                end
                StDrain: begin
                    if (imem_rvalid && (stale_q != '0)) begin
                        stale_d = stale_q - CntW'(1);
                        outst_d = outst_q - CntW'(1);
                    end
                    if (stale_d == '0) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
            if (deq) begin
                head_d = head_q + PtrW'(1);
            end
            count_d = count_q + CntW'(enq) - CntW'(deq);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pc_hold_q  <= 64'h0;
            count_q    <= '0;
            outst_q    <= '0;
            stale_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pc_hold_q  <= pc_hold_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            stale_q    <= stale_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // FIFO storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]    <= resp_pc_q;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        enq |-> (count_q != DepthCnt));

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer that sits directly upstream of the IF/ID pipeline register. It replaces the direct PC-to-instruction-memory path with a decoupled fetch.
- Generates sequential fetch addresses and issues them to a variable-latency instruction memory with a req/ready handshake.
- Stores returned instructions, tagged with their PC, in a DEPTH-entry FIFO. The FIFO head is presented to IF/ID.
- Discards wrong-path instructions on a branch redirect from ID.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum number of outstanding memory requests (power of 2, at least 2).
- RESET_PC, 64'h0, first fetch byte address after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low: the block is in reset when rst==0 at a clk edge
- imem_req  out  1  request valid
- imem_addr  out  64  byte address of the request, always 4-aligned
- imem_ready  in  1  memory accepts the request this cycle when imem_req && imem_ready
- imem_rvalid  in  1  response valid; responses return in request order, one per cycle maximum
- imem_rdata  in  32  response instruction
- instr_valid  out  1  FIFO head is valid
- instr_out  out  32  FIFO head instruction
- pc_out  out  64  byte PC of FIFO head
- stall  in  1  IF/ID hold (hazard stall); when 1, the head is not consumed
- redirect  in  1  taken branch resolved in ID; flush
- redirect_pc  in  64  branch target; bits [1:0] forced to 0

Behaviour:
- Reset values (rst==0): fetch_pc=RESET_PC, resp_pc=RESET_PC, count=0, outstanding=0, stale=0, state=RUN, instr_valid=0, instr_out=32'h00000013 (NOP), pc_out=0, imem_req=0.
- Request issue:
  - imem_req = (state==RUN) && !redirect && (count+outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - On handshake (req && ready): fetch_pc += 4 and outstanding += 1.
  - imem_req stays asserted with a stable address until ready.
- Response (state==RUN, no redirect that cycle):
  - imem_rvalid writes {imem_rdata, resp_pc} at the FIFO tail.
  - resp_pc += 4; outstanding -= 1; count += 1.
  - Credit rule guarantees the FIFO never overflows. A response with count==DEPTH is an assertion failure.
- Dequeue:
  - Occurs when instr_valid && !stall. Head pointer advances and count -= 1.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - instr_valid = (count!=0). Outputs come from registered FIFO storage.
  - Latency: rvalid in cycle N with an empty FIFO gives instr_valid in cycle N+1.
- Empty FIFO: instr_valid=0, instr_out=NOP, pc_out holds its last value.
- Redirect (highest priority, any state):
  - FIFO is cleared (count=0, pointers=0); instr_valid=0 from the next cycle.
  - fetch_pc and resp_pc are set to redirect_pc & ~3.
  - stale = outstanding minus 1 if imem_rvalid that cycle (that response is dropped).
  - outstanding is set equal to stale.
  - No request is issued in the redirect cycle.
  - Next state: DRAIN if stale>0, else RUN.
- State machine RUN/DRAIN:
  - DRAIN: no requests are issued.
  - Each imem_rvalid is discarded, with stale -= 1 and outstanding -= 1.
  - When stale reaches 0 (including the cycle it decrements to 0), the next state is RUN.
  - A redirect in DRAIN recomputes stale per the redirect rule and stays in DRAIN if stale>0.
- Counters: count, outstanding, and stale are each clog2(DEPTH)+1 bits. PC increments wrap modulo 2^64.
- Reset mid-operation:
  - All state is cleared per the reset values.
  - The memory is reset by the same rst. Responses to pre-reset requests are not tracked.
  - imem_rvalid is ignored while rst==0.

Test Plan:
- Reset, then release with RESET_PC=0, 1-cycle memory, no stalls -> requests at 0x0, 0x4, 0x8, … on consecutive cycles. instr_valid rises 2 cycles after the first handshake. pc_out sequence is 0x0, 0x4, 0x8 with matching instructions.
- stall held high for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, imem_req drops to 0, count=4, head stays pc_out=0x0. On stall release, the queue drains one entry per cycle and requests resume.
- Memory latency 3 cycles, 3 requests outstanding, redirect with redirect_pc=0x103 -> FIFO empties next cycle and state=DRAIN. The 3 stale responses are discarded. The next request goes to 0x100 and the first delivered pc_out is 0x100.
- Redirect with outstanding=0 -> no DRAIN; request to the target is issued the following cycle.
- Redirect in DRAIN (stale=2) to 0x200, with a response arriving the same cycle -> stale=1, fetch resumes at 0x200 after one more response is discarded, and no instruction from 0x100 appears.
- rst driven low mid-burst with count=3 -> next cycle instr_valid=0 and imem_req=0. After release, fetching restarts at RESET_PC.
